// File: rtl/plot_arbiter.sv
// Round-robin arbiter sharing one framebuffer write port among N_REQ pixel
// requesters, with a built-in full-screen clear sweep that outranks them.
module plot_arbiter #(
   parameter int N_REQ    = 4,
   parameter int XW       = 8,
   parameter int YW       = 7,
   parameter int CW       = 3,
   parameter int XMAX     = 159,
   parameter int YMAX     = 119,
   parameter int BG_COLOR = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*XW-1:0] req_x,
   input  logic [N_REQ*YW-1:0] req_y,
   input  logic [N_REQ*CW-1:0] req_color,
   input  logic                clear_req,
   output logic [N_REQ-1:0]    gnt,
   output logic                plot,
   output logic [XW-1:0]       x_out,
   output logic [YW-1:0]       y_out,
   output logic [CW-1:0]       color_out,
   output logic                busy,
   output logic                clear_done
);

   localparam int IW = $clog2(N_REQ);

   typedef enum logic [1:0] {IDLE, GRANT, CLEAR} state_t;

   state_t          state;
   logic            clear_pending;
   logic [IW-1:0]   rr;
   logic            any_req;
   int              win;
   int              scan_idx;

   // Scan from the farthest slot down to rr+1 so the nearest asserted
   // requester after the last winner is the final (winning) assignment.
   always_comb begin
      any_req  = 1'b0;
      win      = 0;
      scan_idx = 0;
      for (int k = N_REQ; k >= 1; k--) begin
         scan_idx = (int'(rr) + k) % N_REQ;
         if (req[scan_idx]) begin
            any_req = 1'b1;
            win     = scan_idx;
         end
      end
   end

   // Single registered FSM; every output is a flop so nothing leaks
   // combinationally from the requesters to the framebuffer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         gnt           <= '0;
         plot          <= 1'b0;
         x_out         <= '0;
         y_out         <= '0;
         color_out     <= '0;
         busy          <= 1'b0;
         clear_done    <= 1'b0;
         clear_pending <= 1'b0;
         rr            <= IW'(N_REQ - 1);
      end else begin
         gnt        <= '0;
         clear_done <= 1'b0;
         case (state)
            IDLE: begin
               if (clear_pending || clear_req) begin
                  state         <= CLEAR;
                  x_out         <= '0;
                  y_out         <= '0;
                  color_out     <= CW'(BG_COLOR);
                  plot          <= 1'b1;
                  busy          <= 1'b1;
                  clear_pending <= 1'b0;
               end else if (any_req) begin
                  state      <= GRANT;
                  gnt[win]   <= 1'b1;
                  plot       <= 1'b1;
                  busy       <= 1'b1;
                  x_out      <= req_x[win*XW +: XW];
                  y_out      <= req_y[win*YW +: YW];
                  color_out  <= req_color[win*CW +: CW];
                  rr         <= IW'(win);
               end else begin
                  plot <= 1'b0;
                  busy <= 1'b0;
               end
            end
            GRANT: begin
               state <= IDLE;
               plot  <= 1'b0;
               busy  <= 1'b0;
               if (clear_req)
                  clear_pending <= 1'b1;
            end
            CLEAR: begin
               // clear_req is deliberately ignored here: no restart, no pending.
               if (x_out == XW'(XMAX) && y_out == YW'(YMAX)) begin
                  state      <= IDLE;
                  plot       <= 1'b0;
                  busy       <= 1'b0;
                  clear_done <= 1'b1;
               end else if (x_out == XW'(XMAX)) begin
                  x_out <= '0;
                  y_out <= y_out + 1'b1;
               end else begin
                  x_out <= x_out + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               plot  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
